// File: rtl/dat_xfer_ctrl.sv
// SD host DAT-path transfer sequencer: accepts start requests, latches transfer
// parameters, gates physical-layer flags from FIFO status and tracks timeouts/busy.
module dat_xfer_ctrl #(
  parameter int BLOCK_SZ_WIDTH  = 12,
  parameter int BLOCK_CNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH   = 16
) (
  input  logic                       sd_clk,
  input  logic                       rst,
  input  logic                       start_write,
  input  logic                       start_read,
  input  logic                       abort,
  input  logic                       err_clr,
  input  logic [BLOCK_SZ_WIDTH-1:0]  block_sz_in,
  input  logic [BLOCK_CNT_WIDTH-1:0] block_cnt_in,
  input  logic                       multiple_in,
  input  logic                       tx_fifo_empty,
  input  logic                       rx_fifo_full,
  input  logic                       tx_buf_rd_enb,
  input  logic                       rx_buf_wr_enb,
  input  logic                       card_busy,
  input  logic                       tf_finished,
  output logic                       write_flag,
  output logic                       read_flag,
  output logic [BLOCK_SZ_WIDTH-1:0]  block_sz,
  output logic [BLOCK_CNT_WIDTH-1:0] block_cnt,
  output logic                       multiple,
  output logic                       phys_rst,
  output logic                       xfer_active,
  output logic                       xfer_done,
  output logic [3:0]                 error_status
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CARD, S_WRITE, S_WAIT_BUSY, S_READ, S_ABORT, S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0]   tmr_q, tmr_d;
  logic [3:0]                 err_q, err_d, err_set;
  logic [BLOCK_SZ_WIDTH-1:0]  block_sz_q;
  logic [BLOCK_CNT_WIDTH-1:0] block_cnt_q;
  logic                       multiple_q;

  logic timed_state, timeout, abort_hit, start_any, params_bad, progress;

  assign timed_state = (state_q == S_WAIT_CARD) || (state_q == S_WRITE) ||
                       (state_q == S_WAIT_BUSY) || (state_q == S_READ);
  assign timeout     = timed_state && (tmr_q == '1);
  assign abort_hit   = timed_state && abort;
  assign start_any   = (state_q == S_IDLE) && (start_write || start_read);
  assign params_bad  = (block_sz_in == '0) || (block_sz_in[1:0] != 2'b00) ||
                       (multiple_in && (block_cnt_in == '0));
  assign progress    = ((state_q == S_WRITE) && tx_buf_rd_enb) ||
                       ((state_q == S_READ) && rx_buf_wr_enb);

  always_comb begin
    state_d = state_q;
    err_set = 4'b0000;
    if (abort_hit) begin
      state_d    = S_ABORT;
      err_set[3] = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_any) begin
            if (params_bad) begin
              state_d    = S_DONE;
              err_set[2] = 1'b1;
            end else begin
              state_d = start_write ? S_WAIT_CARD : S_READ;
            end
          end
        end
        S_WAIT_CARD: begin
          if (!card_busy) begin
            state_d = S_WRITE;
          end else if (timeout) begin
            state_d    = S_ABORT;
            err_set[1] = 1'b1;
          end
        end
        S_WRITE: begin
          if (tf_finished) begin
            state_d = S_WAIT_BUSY;
          end else if (timeout) begin
            state_d    = S_ABORT;
            err_set[0] = 1'b1;
          end
        end
        S_WAIT_BUSY: begin
          // The first two cycles are blind to card_busy so a late busy onset is not missed.
          if ((tmr_q >= TIMEOUT_WIDTH'(2)) && !card_busy) begin
            state_d = S_DONE;
          end else if (timeout) begin
            state_d    = S_ABORT;
            err_set[1] = 1'b1;
          end
        end
        S_READ: begin
          if (tf_finished) begin
            state_d = S_DONE;
          end else if (timeout) begin
            state_d    = S_ABORT;
            err_set[0] = 1'b1;
          end
        end
        S_ABORT: state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tmr_d = tmr_q;
    if ((state_d != state_q) || progress) begin
      tmr_d = '0;
    end else if (tmr_q != '1) begin
      tmr_d = tmr_q + TIMEOUT_WIDTH'(1);
    end
  end

  // A bit raised in the same cycle as err_clr survives the clear.
  assign err_d = (err_clr ? 4'b0000 : err_q) | err_set;

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      err_q       <= 4'b0000;
      block_sz_q  <= '0;
      block_cnt_q <= '0;
      multiple_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      if (start_any) begin
        block_sz_q  <= block_sz_in;
        block_cnt_q <= multiple_in ? block_cnt_in : BLOCK_CNT_WIDTH'(1);
        multiple_q  <= multiple_in;
      end
    end
  end

  assign write_flag   = (state_q == S_WRITE) && !tx_fifo_empty;
  assign read_flag    = (state_q == S_READ) && !rx_fifo_full;
  assign phys_rst     = (state_q == S_ABORT);
  assign xfer_done    = (state_q == S_DONE);
  assign xfer_active  = (state_q != S_IDLE);
  assign error_status = err_q;
  assign block_sz     = block_sz_q;
  assign block_cnt    = block_cnt_q;
  assign multiple     = multiple_q;

endmodule

// File: tb/tb_dat_xfer_ctrl.sv
// Scenario bench for dat_xfer_ctrl: expectations come from transaction-level
// rules (parameter validity, latched values, error bits, flag gating).
module tb_dat_xfer_ctrl;
  localparam int BSW = 12;
  localparam int BCW = 16;
  localparam int TW  = 16;

  logic           sd_clk = 1'b0;
  logic           rst, start_write, start_read, abort, err_clr;
  logic [BSW-1:0] block_sz_in;
  logic [BCW-1:0] block_cnt_in;
  logic           multiple_in, tx_fifo_empty, rx_fifo_full, tx_buf_rd_enb, rx_buf_wr_enb;
  logic           card_busy, tf_finished;
  logic           write_flag, read_flag, multiple, phys_rst, xfer_active, xfer_done;
  logic [BSW-1:0] block_sz;
  logic [BCW-1:0] block_cnt;
  logic [3:0]     error_status;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model of the latched parameters and sticky error bits.
  logic [3:0]     exp_err;
  logic [BSW-1:0] exp_sz;
  logic [BCW-1:0] exp_cnt;
  logic           exp_mult;

  always #5 sd_clk = ~sd_clk;

  dat_xfer_ctrl #(.BLOCK_SZ_WIDTH(BSW), .BLOCK_CNT_WIDTH(BCW), .TIMEOUT_WIDTH(TW)) dut (
    .sd_clk(sd_clk), .rst(rst), .start_write(start_write), .start_read(start_read),
    .abort(abort), .err_clr(err_clr), .block_sz_in(block_sz_in), .block_cnt_in(block_cnt_in),
    .multiple_in(multiple_in), .tx_fifo_empty(tx_fifo_empty), .rx_fifo_full(rx_fifo_full),
    .tx_buf_rd_enb(tx_buf_rd_enb), .rx_buf_wr_enb(rx_buf_wr_enb), .card_busy(card_busy),
    .tf_finished(tf_finished), .write_flag(write_flag), .read_flag(read_flag),
    .block_sz(block_sz), .block_cnt(block_cnt), .multiple(multiple), .phys_rst(phys_rst),
    .xfer_active(xfer_active), .xfer_done(xfer_done), .error_status(error_status)
  );

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic start_xfer(input bit wr, input bit rd, input int sz, input int cnt,
                            input bit mult, output bit ok);
    block_sz_in  = BSW'(sz);
    block_cnt_in = BCW'(cnt);
    multiple_in  = mult;
    start_write  = wr;
    start_read   = rd;
    ok = (sz != 0) && (sz % 4 == 0) && !(mult && cnt == 0);
    if (wr || rd) begin
      exp_sz   = BSW'(sz);
      exp_cnt  = mult ? BCW'(cnt) : BCW'(1);
      exp_mult = mult;
      if (!ok) exp_err[2] = 1'b1;
    end
    tick();
    start_write = 1'b0;
    start_read  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_write = 0; start_read = 0; abort = 0; err_clr = 0;
    block_sz_in = '0; block_cnt_in = '0; multiple_in = 0; tx_fifo_empty = 1; rx_fifo_full = 1;
    tx_buf_rd_enb = 0; rx_buf_wr_enb = 0; card_busy = 0; tf_finished = 0;
    exp_err = 4'b0; exp_sz = '0; exp_cnt = '0; exp_mult = 1'b0;
    tick(); tick();
    n_checks++;
    if ({write_flag, read_flag, xfer_active, xfer_done, phys_rst, multiple, error_status,
         block_sz, block_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wf=%b rf=%b act=%b done=%b prst=%b mult=%b err=%b sz=%0d cnt=%0d, required all 0",
               write_flag, read_flag, xfer_active, xfer_done, phys_rst, multiple, error_status, block_sz, block_cnt);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({xfer_active, xfer_done, phys_rst} !== 3'b000) begin
      n_fail++; $display("FAIL reset_release: got act=%b done=%b prst=%b, required 000", xfer_active, xfer_done, phys_rst);
    end
    $display("reset: outputs after reset checked");
  endtask

  task automatic test_single_write();
    bit ok;
    int done_cnt;
    tx_fifo_empty = 0; card_busy = 0;
    start_xfer(1, 0, 512, $urandom_range(0, 65535), 0, ok);
    n_checks++;
    if ({xfer_active, write_flag, read_flag} !== 3'b100) begin
      n_fail++; $display("FAIL write_wait_card: got act/wf/rf=%b%b%b, required 100", xfer_active, write_flag, read_flag);
    end
    n_checks++;
    if ({block_sz, block_cnt, multiple} !== {exp_sz, exp_cnt, exp_mult}) begin
      n_fail++; $display("FAIL write_latch: got sz=%0d cnt=%0d mult=%b, required sz=%0d cnt=%0d mult=%b",
                         block_sz, block_cnt, multiple, exp_sz, exp_cnt, exp_mult);
    end
    tick();
    n_checks++;
    if (write_flag !== 1'b1) begin
      n_fail++; $display("FAIL write_latency: got write_flag=%b at k+2, required 1", write_flag);
    end
    repeat (12) begin
      tx_fifo_empty = 1'($urandom); tx_buf_rd_enb = 1'($urandom);
      #1;
      n_checks++;
      if ({write_flag, read_flag} !== {~tx_fifo_empty, 1'b0}) begin
        n_fail++; $display("FAIL write_flag_gate: got wf=%b rf=%b with tx_empty=%b, required wf=%b rf=0",
                           write_flag, read_flag, tx_fifo_empty, ~tx_fifo_empty);
      end
      tick();
    end
    tx_fifo_empty = 0; tx_buf_rd_enb = 0; tf_finished = 1; card_busy = 1;
    tick();
    tf_finished = 0;
    n_checks++;
    if ({write_flag, xfer_done} !== 2'b00) begin
      n_fail++; $display("FAIL write_after_tf: got wf=%b done=%b, required 00", write_flag, xfer_done);
    end
    done_cnt = 0;
    repeat (9) begin
      tick();
      done_cnt += int'(xfer_done) + int'(write_flag);
    end
    n_checks++;
    if (done_cnt != 0) begin
      n_fail++; $display("FAIL write_busy_hold: got %0d done/flag cycles while busy, required 0", done_cnt);
    end
    card_busy = 0;
    tick();
    n_checks++;
    if (xfer_done !== 1'b1) begin
      n_fail++; $display("FAIL write_done_release: got xfer_done=%b, required 1", xfer_done);
    end
    done_cnt = 0;
    repeat (4) begin tick(); done_cnt += int'(xfer_done); end
    n_checks++;
    if (done_cnt != 0 || error_status !== exp_err) begin
      n_fail++; $display("FAIL write_single_done: got extra_done=%0d err=%b, required 0 and %b", done_cnt, error_status, exp_err);
    end
    $display("single_write: sz=%0d cnt=%0d err=%b", block_sz, block_cnt, error_status);
  endtask

  task automatic test_multi_read();
    bit ok;
    rx_fifo_full = 1'($urandom);
    start_xfer(0, 1, 4 * $urandom_range(1, 1023), 3, 1, ok);
    n_checks++;
    if ({read_flag, write_flag} !== {~rx_fifo_full, 1'b0}) begin
      n_fail++; $display("FAIL read_latency: got rf=%b wf=%b with rx_full=%b, required rf=%b wf=0",
                         read_flag, write_flag, rx_fifo_full, ~rx_fifo_full);
    end
    repeat (20) begin
      rx_fifo_full = 1'($urandom); rx_buf_wr_enb = 1'($urandom);
      #1;
      n_checks++;
      if ({read_flag, write_flag, block_cnt, block_sz} !== {~rx_fifo_full, 1'b0, exp_cnt, exp_sz}) begin
        n_fail++; $display("FAIL read_flag_gate: got rf=%b wf=%b cnt=%0d sz=%0d, required rf=%b wf=0 cnt=%0d sz=%0d",
                           read_flag, write_flag, block_cnt, block_sz, ~rx_fifo_full, exp_cnt, exp_sz);
      end
      tick();
    end
    rx_fifo_full = 0; rx_buf_wr_enb = 0; tf_finished = 1;
    tick();
    tf_finished = 0;
    n_checks++;
    if ({read_flag, xfer_done} !== 2'b01) begin
      n_fail++; $display("FAIL read_done: got rf=%b done=%b after tf_finished, required rf=0 done=1", read_flag, xfer_done);
    end
    tick();
    n_checks++;
    if ({xfer_done, xfer_active, block_cnt, multiple, error_status} !== {2'b00, BCW'(3), 1'b1, exp_err}) begin
      n_fail++; $display("FAIL read_idle_hold: got done=%b act=%b cnt=%0d mult=%b err=%b, required 0 0 3 1 %b",
                         xfer_done, xfer_active, block_cnt, multiple, error_status, exp_err);
    end
    $display("multi_read: sz=%0d cnt=%0d err=%b", block_sz, block_cnt, error_status);
  endtask

  task automatic test_wait_card_busy();
    bit ok;
    int first, done_cnt;
    card_busy = 1; tx_fifo_empty = 0;
    start_xfer(1, 0, 4 * $urandom_range(1, 1023), $urandom_range(1, 65535), 1'($urandom), ok);
    repeat ($urandom_range(3, 8)) begin
      n_checks++;
      if ({xfer_active, write_flag} !== 2'b10) begin
        n_fail++; $display("FAIL wait_card_hold: got act=%b wf=%b while card busy, required 1 0", xfer_active, write_flag);
      end
      tick();
    end
    card_busy = 0;
    tick();
    n_checks++;
    if (write_flag !== 1'b1) begin
      n_fail++; $display("FAIL wait_card_release: got wf=%b, required 1", write_flag);
    end
    tf_finished = 1;
    tick();
    tf_finished = 0;
    first = -1; done_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (xfer_done) begin
        done_cnt++;
        if (first < 0) first = i;
      end
    end
    n_checks++;
    if (done_cnt != 1 || first < 2 || first > 3) begin
      n_fail++; $display("FAIL busy_blind_window: got %0d done pulses first at +%0d, required 1 pulse at +2..+3", done_cnt, first);
    end
    $display("wait_card_busy: done at +%0d after tf_finished", first);
  endtask

  task automatic test_data_timeout();
    bit ok;
    int cyc, prst_cnt;
    tx_fifo_empty = 1; card_busy = 0; tx_buf_rd_enb = 0;
    start_xfer(1, 0, 512, 1, 0, ok);
    tick();
    cyc = 0;
    while (!phys_rst && cyc < 70000) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc < 65535 || cyc > 65537) begin
      n_fail++; $display("FAIL data_timeout_time: got phys_rst after %0d idle cycles, required 65535..65537", cyc);
    end
    exp_err[0] = 1'b1;
    tx_fifo_empty = 0;
    #1;
    n_checks++;
    if ({phys_rst, write_flag, xfer_done, error_status} !== {3'b100, exp_err}) begin
      n_fail++; $display("FAIL data_timeout_abort: got prst=%b wf=%b done=%b err=%b, required 1 0 0 %b",
                         phys_rst, write_flag, xfer_done, error_status, exp_err);
    end
    prst_cnt = 1;
    tick();
    n_checks++;
    if ({phys_rst, xfer_done} !== 2'b01) begin
      n_fail++; $display("FAIL data_timeout_done: got prst=%b done=%b, required 0 1", phys_rst, xfer_done);
    end
    repeat (3) begin tick(); prst_cnt += int'(phys_rst); end
    n_checks++;
    if (prst_cnt != 1 || error_status !== 4'b0001) begin
      n_fail++; $display("FAIL data_timeout_status: got %0d phys_rst pulses err=%b, required 1 and 0001", prst_cnt, error_status);
    end
    err_clr = 1; tick(); err_clr = 0; exp_err = 4'b0;
    n_checks++;
    if (error_status !== exp_err) begin
      n_fail++; $display("FAIL data_timeout_clr: got err=%b, required %b", error_status, exp_err);
    end
    $display("data_timeout: phys_rst after %0d cycles", cyc);
  endtask

  task automatic test_abort_read();
    bit ok;
    abort = 1; tick(); abort = 0;
    n_checks++;
    if ({xfer_active, phys_rst, error_status} !== {2'b00, exp_err}) begin
      n_fail++; $display("FAIL abort_idle: got act=%b prst=%b err=%b, required 0 0 %b", xfer_active, phys_rst, error_status, exp_err);
    end
    start_xfer(0, 1, 4 * $urandom_range(1, 1023), $urandom_range(1, 65535), 1, ok);
    repeat ($urandom_range(2, 6)) begin
      rx_fifo_full = 1'($urandom); rx_buf_wr_enb = 1'($urandom); tick();
    end
    rx_fifo_full = 0; rx_buf_wr_enb = 0; abort = 1; tf_finished = 1;
    tick();
    abort = 0; tf_finished = 0; exp_err[3] = 1'b1;
    n_checks++;
    if ({phys_rst, read_flag, xfer_done, error_status} !== {3'b100, exp_err}) begin
      n_fail++; $display("FAIL abort_read: got prst=%b rf=%b done=%b err=%b, required 1 0 0 %b",
                         phys_rst, read_flag, xfer_done, error_status, exp_err);
    end
    tick();
    n_checks++;
    if ({phys_rst, xfer_done, read_flag} !== 3'b010) begin
      n_fail++; $display("FAIL abort_read_done: got prst=%b done=%b rf=%b, required 0 1 0", phys_rst, xfer_done, read_flag);
    end
    tick();
    $display("abort_read: err=%b", error_status);
    err_clr = 1; tick(); err_clr = 0; exp_err = 4'b0;
  endtask

  task automatic test_invalid_params();
    bit ok, wr;
    int sz, cnt;
    bit mult;
    card_busy = 0; tx_fifo_empty = 0; rx_fifo_full = 0;
    for (int i = 0; i < 10; i++) begin
      sz   = (i == 0) ? 0 : (i == 1) ? 510 : int'($urandom_range(0, 4095));
      mult = 1'($urandom);
      cnt  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 65535));
      wr   = 1'($urandom);
      start_xfer(wr, ~wr, sz, cnt, mult, ok);
      n_checks++;
      if ({block_sz, block_cnt, multiple} !== {exp_sz, exp_cnt, exp_mult}) begin
        n_fail++; $display("FAIL param_latch: got sz=%0d cnt=%0d mult=%b, required sz=%0d cnt=%0d mult=%b",
                           block_sz, block_cnt, multiple, exp_sz, exp_cnt, exp_mult);
      end
      if (!ok) begin
        n_checks++;
        if ({xfer_done, write_flag, read_flag, xfer_active, error_status} !== {4'b1001, exp_err}) begin
          n_fail++; $display("FAIL invalid_done: got done=%b wf=%b rf=%b act=%b err=%b, required 1 0 0 1 %b",
                             xfer_done, write_flag, read_flag, xfer_active, error_status, exp_err);
        end
        tick();
      end else begin
        abort = 1; tick(); abort = 0; exp_err[3] = 1'b1;
        n_checks++;
        if ({phys_rst, error_status} !== {1'b1, exp_err}) begin
          n_fail++; $display("FAIL valid_abort: got prst=%b err=%b, required 1 %b", phys_rst, error_status, exp_err);
        end
        tick(); tick();
      end
      $display("params: wr=%b sz=%0d cnt=%0d mult=%b valid=%b err=%b", wr, sz, cnt, mult, ok, error_status);
      err_clr = 1; tick(); err_clr = 0; exp_err = 4'b0;
      n_checks++;
      if ({error_status, xfer_active} !== {exp_err, 1'b0}) begin
        n_fail++; $display("FAIL err_clr: got err=%b act=%b, required %b 0", error_status, xfer_active, exp_err);
      end
    end
    // A fresh invalid-param error raised alongside err_clr must survive; older bits must go.
    start_xfer(0, 1, 6, 1, 0, ok); tick();
    start_xfer(0, 1, 64, 1, 0, ok);
    abort = 1; tick(); abort = 0; exp_err[3] = 1'b1; tick(); tick();
    n_checks++;
    if (error_status !== exp_err) begin
      n_fail++; $display("FAIL err_accumulate: got err=%b, required %b", error_status, exp_err);
    end
    err_clr = 1; exp_err = 4'b0;
    start_xfer(1, 0, 0, 1, 0, ok);
    err_clr = 0;
    n_checks++;
    if (error_status !== exp_err) begin
      n_fail++; $display("FAIL err_set_beats_clr: got err=%b, required %b", error_status, exp_err);
    end
    tick();
    err_clr = 1; tick(); err_clr = 0; exp_err = 4'b0;
    $display("err_priority: err=%b", error_status);
  endtask

  task automatic test_simul_start_rst();
    bit ok;
    int bad;
    card_busy = 0; tx_fifo_empty = 0; rx_fifo_full = 0;
    start_xfer(1, 1, 2048, $urandom_range(1, 65535), 1, ok);
    n_checks++;
    if ({xfer_active, read_flag, block_cnt} !== {2'b10, exp_cnt}) begin
      n_fail++; $display("FAIL simul_start: got act=%b rf=%b cnt=%0d, required 1 0 %0d", xfer_active, read_flag, block_cnt, exp_cnt);
    end
    bad = 0;
    repeat (5) begin tick(); bad += int'(read_flag) + int'(!write_flag); end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL simul_write_path: got %0d cycles with rf=1 or wf=0, required 0", bad);
    end
    rst = 1;
    tick();
    n_checks++;
    if ({write_flag, read_flag, xfer_active, xfer_done, phys_rst, multiple, error_status,
         block_sz, block_cnt} !== '0) begin
      n_fail++; $display("FAIL rst_mid_write: got wf=%b act=%b done=%b prst=%b sz=%0d cnt=%0d, required all 0",
                         write_flag, xfer_active, xfer_done, phys_rst, block_sz, block_cnt);
    end
    tick(); rst = 0;
    bad = 0;
    repeat (5) begin tick(); bad += int'(xfer_done) + int'(phys_rst) + int'(write_flag); end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rst_no_done: got %0d done/phys_rst/flag cycles after reset, required 0", bad);
    end
    $display("simul_start_rst: write path taken, reset cleared outputs");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_multi_read();
    test_wait_card_busy();
    test_abort_read();
    test_invalid_params();
    test_simul_start_rst();
    test_data_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
